// File: rtl/spi_slave_ctrl_pkg.sv
// ============================================================================
// spi_slave_ctrl_pkg : FSM encoding and frame-geometry helpers for the SPI slave
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_slave_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int FRAME8  = 8;
   localparam int FRAME16 = 16;

   function automatic logic [4:0] frame_len(input logic dff);
      return dff ? 5'(FRAME16) : 5'(FRAME8);
   endfunction

   // Word bit position for the idx-th bit on the wire.
   function automatic logic [3:0] bit_pos(input logic [3:0] idx, input logic lsb, input logic dff);
      if (lsb)
         return idx;
      return (dff ? 4'd15 : 4'd7) - idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with level-change detect on its output
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   input  logic i_reset_val,
   output logic o_sync,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{i_reset_val}};
         r_dly  <= i_reset_val;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_dly  <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_edge = o_sync ^ r_dly;

endmodule

`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
// ============================================================================
// spi_slave_ctrl : SPI responder, 8/16-bit frames, all CPOL/CPHA modes, valid/ready TX/RX
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_ctrl
   import spi_slave_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic        DFF,
   input  logic        LSBFIRST,
   input  logic [15:0] i_TX_Byte,
   input  logic        i_TX_Vaild,
   output logic        o_TX_Ready,
   output logic        o_RX_Vaild,
   output logic [15:0] o_RX_Byte,
   output logic        o_Busy,
   output logic        o_Underrun,
   output logic        o_Frame_Err,
   input  logic        i_SPI_SCK,
   input  logic        i_SPI_CS,
   input  logic        i_SPI_MOSI,
   output logic        o_SPI_MISO,
   output logic        o_SPI_MISO_OE
);

   state_t                 r_state;
   logic                   r_cpol, r_cpha, r_dff, r_lsb;
   logic [15:0]            r_hold, r_tx_sh, r_rx_sh;
   logic [4:0]             r_cnt;
   logic [SYNC_STAGES-1:0] r_mosi_sync;

   logic w_sck_sync, w_sck_edge, w_cs_sync, w_cs_edge;
   logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
   logic w_lead, w_trail, w_sample, w_shift, w_last, w_mosi;
   logic w_cfg_lsb, w_cfg_dff, w_first_bit;
   logic [3:0]  w_pos;
   logic [15:0] w_load_word, w_rx_next;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_async     (i_SPI_SCK),
      .i_reset_val (CPOL),
      .o_sync      (w_sck_sync),
      .o_edge      (w_sck_edge)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_async     (i_SPI_CS),
      .i_reset_val (1'b1),
      .o_sync      (w_cs_sync),
      .o_edge      (w_cs_edge)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_mosi_sync <= '0;
      else
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
   end

   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_rise  = w_cs_edge & w_cs_sync;
   assign w_cs_fall  = w_cs_edge & ~w_cs_sync;
   assign w_sck_rise = w_sck_edge & w_sck_sync;
   assign w_sck_fall = w_sck_edge & ~w_sck_sync;
   assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
   assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
   assign w_sample   = r_cpha ? w_trail : w_lead;
   // In mode CPHA=0 a trailing edge with zero bits sampled follows a completed frame: no shift.
   assign w_shift    = r_cpha ? w_lead : (w_trail & (r_cnt != 5'd0));
   assign w_pos      = bit_pos(r_cnt[3:0], r_lsb, r_dff);
   assign w_last     = w_sample && (r_cnt == frame_len(r_dff) - 5'd1);

   // Frame starts from IDLE use the live config pins; back-to-back starts use the latched copy.
   assign w_cfg_lsb   = (r_state == ST_IDLE) ? LSBFIRST : r_lsb;
   assign w_cfg_dff   = (r_state == ST_IDLE) ? DFF : r_dff;
   assign w_load_word = o_TX_Ready ? 16'h0000 : r_hold;
   assign w_first_bit = w_load_word[bit_pos(4'd0, w_cfg_lsb, w_cfg_dff)];

   always_comb begin
      w_rx_next        = r_rx_sh;
      w_rx_next[w_pos] = w_mosi;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cpol        <= 1'b0;
         r_cpha        <= 1'b0;
         r_dff         <= 1'b0;
         r_lsb         <= 1'b0;
         r_hold        <= 16'h0000;
         r_tx_sh       <= 16'h0000;
         r_rx_sh       <= 16'h0000;
         r_cnt         <= 5'd0;
         o_TX_Ready    <= 1'b1;
         o_RX_Vaild    <= 1'b0;
         o_RX_Byte     <= 16'h0000;
         o_Busy        <= 1'b0;
         o_Underrun    <= 1'b0;
         o_Frame_Err   <= 1'b0;
         o_SPI_MISO    <= 1'b0;
         o_SPI_MISO_OE <= 1'b0;
      end else begin
         o_RX_Vaild  <= 1'b0;
         o_Underrun  <= 1'b0;
         o_Frame_Err <= 1'b0;

         if (i_TX_Vaild && o_TX_Ready) begin
            r_hold     <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state       <= ST_SHIFT;
                  r_cpol        <= CPOL;
                  r_cpha        <= CPHA;
                  r_dff         <= DFF;
                  r_lsb         <= LSBFIRST;
                  r_cnt         <= 5'd0;
                  r_rx_sh       <= 16'h0000;
                  r_tx_sh       <= w_load_word;
                  o_Underrun    <= o_TX_Ready;
                  o_TX_Ready    <= 1'b1;
                  o_Busy        <= 1'b1;
                  o_SPI_MISO_OE <= 1'b1;
                  o_SPI_MISO    <= CPHA ? 1'b0 : w_first_bit;
               end
            end

            ST_SHIFT: begin
               if (w_last) begin
                  o_RX_Byte  <= w_rx_next;
                  o_RX_Vaild <= 1'b1;
                  r_cnt      <= 5'd0;
                  r_rx_sh    <= 16'h0000;
                  if (w_cs_sync) begin
                     r_state       <= ST_IDLE;
                     o_Busy        <= 1'b0;
                     o_SPI_MISO_OE <= 1'b0;
                     o_SPI_MISO    <= 1'b0;
                  end else begin
                     r_tx_sh    <= w_load_word;
                     o_Underrun <= o_TX_Ready;
                     o_TX_Ready <= 1'b1;
                     if (!r_cpha)
                        o_SPI_MISO <= w_first_bit;
                  end
               end else if (w_cs_rise) begin
                  r_state       <= ST_IDLE;
                  r_cnt         <= 5'd0;
                  o_Frame_Err   <= (r_cnt != 5'd0) | w_sample;
                  o_Busy        <= 1'b0;
                  o_SPI_MISO_OE <= 1'b0;
                  o_SPI_MISO    <= 1'b0;
               end else if (w_sample) begin
                  r_rx_sh <= w_rx_next;
                  r_cnt   <= r_cnt + 5'd1;
               end else if (w_shift) begin
                  o_SPI_MISO <= r_tx_sh[w_pos];
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
